// File: rtl/sequential_arithmetic_left_shifter_pkg.sv
// Shared types and width helpers for the sequential arithmetic left shifter.
package sequential_arithmetic_left_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shl_state_t;

    // A 2-bit operand still needs a 1-bit amount field, so never return 0.
    function automatic int shl_shw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int SHL_DEFAULT_N   = 8;
    localparam int SHL_DEFAULT_SHW = shl_shw(SHL_DEFAULT_N);

endpackage

// File: rtl/sequential_arithmetic_left_shifter.sv
// Multi-cycle arithmetic left shifter: one bit per clock, sticky signed overflow,
// start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; result and overflow hold
// SHIFT | shifting the working register, count_q shifts remaining
// DONE  | one-cycle done strobe, result/overflow valid
module sequential_arithmetic_left_shifter
    import sequential_arithmetic_left_shifter_pkg::*;
#(
    parameter int N   = SHL_DEFAULT_N,
    parameter int SHW = shl_shw(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   input_data,
    input  logic [SHW-1:0] shift_amount,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   shifted_result,
    output logic           overflow
);

    shl_state_t     state_q, state_d;
    logic [N-1:0]   work_q, work_d;
    logic [N-1:0]   result_q, result_d;
    logic [SHW-1:0] count_q, count_d;
    logic           ovf_acc_q, ovf_acc_d;
    logic           ovf_q, ovf_d;
    logic           ovf_step;

    // Sign change test on the value before this edge's shift; the accumulator is
    // separate from the visible flag so the output holds while busy.
    assign ovf_step = ovf_acc_q | (work_q[N-1] ^ work_q[N-2]);

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        result_d  = result_q;
        count_d   = count_q;
        ovf_acc_d = ovf_acc_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d    = input_data;
                    count_d   = shift_amount;
                    ovf_acc_d = 1'b0;
                    if (shift_amount == '0) begin
                        state_d  = DONE;
                        result_d = input_data;
                        ovf_d    = 1'b0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d    = work_q << 1;
                count_d   = count_q - SHW'(1);
                ovf_acc_d = ovf_step;
                if (count_q == SHW'(1)) begin
                    state_d  = DONE;
                    result_d = work_q << 1;
                    ovf_d    = ovf_step;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            result_q  <= '0;
            count_q   <= '0;
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            result_q  <= result_d;
            count_q   <= count_d;
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign shifted_result = result_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_sequential_arithmetic_left_shifter.sv
// Self-checking bench for sequential_arithmetic_left_shifter (N=8) using a
// scoreboard queue of expected results.
module tb_sequential_arithmetic_left_shifter;

    localparam int N   = 8;
    localparam int SHW = 3;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   input_data;
    logic [SHW-1:0] shift_amount;
    logic           busy;
    logic           done;
    logic [N-1:0]   shifted_result;
    logic           overflow;

    typedef struct packed {
        logic [N-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [N-1:0] last_res;
    logic         last_ovf;

    sequential_arithmetic_left_shifter #(.N(N), .SHW(SHW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .input_data     (input_data),
        .shift_amount   (shift_amount),
        .busy           (busy),
        .done           (done),
        .shifted_result (shifted_result),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result is d<<k truncated; overflow iff d[7:7-k] not all equal.
    function automatic exp_t model(input logic [N-1:0] d, input int k);
        exp_t e;
        logic [N-1:0] r;
        r = d << k;
        e.res = r;
        e.ovf = 1'b0;
        for (int i = 1; i <= k; i++)
            if (d[N-1-i] != d[N-1]) e.ovf = 1'b1;
        return e;
    endfunction

    // Called at posedge+1 while IDLE; returns at E0+1 with start released.
    task automatic issue(input logic [N-1:0] d, input int k);
        start        = 1'b1;
        input_data   = d;
        shift_amount = SHW'(k);
        @(posedge clk); #1;
        start        = 1'b0;
        input_data   = N'($urandom);
        shift_amount = SHW'($urandom);
        sb.push_back(model(d, k));
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        input_data = '0;
        shift_amount = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, shifted_result, overflow} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_values: busy=%b done=%b res=%h ovf=%b, want 0/0/00/0",
                     busy, done, shifted_result, overflow);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        last_res = '0;
        last_ovf = 1'b0;
    endtask

    task automatic test_busy_window;
        int   b;
        exp_t e;
        issue(8'h03, 2);
        b = 0;
        while (busy === 1'b1 && b < 40) begin
            b++;
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        n_cmp++;
        if (b != 3) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d, want 3", b);
        end
        n_cmp++;
        if (shifted_result !== e.res || overflow !== e.ovf) begin
            n_err++;
            $display("FAIL busy_result: res=%h ovf=%b, want %h/%b",
                     shifted_result, overflow, e.res, e.ovf);
        end
        last_res = e.res;
        last_ovf = e.ovf;
    endtask

    task automatic test_vectors;
        logic [N-1:0] vd[5] = '{8'hF0, 8'h40, 8'hAA, 8'h01, 8'hC0};
        int           vk[5] = '{3, 1, 0, 7, 1};
        int   cyc;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(vd[i], vk[i]);
            wait_done(cyc, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL vec%0d_timeout: no done within %0d cycles", i, cyc);
                sb.delete();
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (cyc != vk[i]) begin
                    n_err++;
                    $display("FAIL vec%0d_latency: got %0d, want %0d", i, cyc, vk[i]);
                end
                n_cmp++;
                if (shifted_result !== e.res || overflow !== e.ovf) begin
                    n_err++;
                    $display("FAIL vec%0d_result: res=%h ovf=%b, want %h/%b",
                             i, shifted_result, overflow, e.res, e.ovf);
                end
                last_res = e.res;
                last_ovf = e.ovf;
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL vec%0d_strobe: done=%b busy=%b after DONE, want 0/0",
                         i, done, busy);
            end
        end
    endtask

    task automatic test_ignored_start;
        int   ndone;
        logic [N-1:0] r;
        logic         o;
        exp_t e;
        issue(8'h03, 2);
        n_cmp++;
        if (shifted_result !== last_res || overflow !== last_ovf) begin
            n_err++;
            $display("FAIL hold_while_busy: res=%h ovf=%b, want %h/%b",
                     shifted_result, overflow, last_res, last_ovf);
        end
        start        = 1'b1;
        input_data   = 8'hFF;
        shift_amount = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        r = '0;
        o = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) begin
                ndone++;
                r = shifted_result;
                o = overflow;
            end
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        n_cmp++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL ignored_start_dones: got %0d, want 1", ndone);
        end
        n_cmp++;
        if (r !== e.res || o !== e.ovf) begin
            n_err++;
            $display("FAIL ignored_start_result: res=%h ovf=%b, want %h/%b", r, o, e.res, e.ovf);
        end
        last_res = e.res;
        last_ovf = e.ovf;
    endtask

    task automatic test_reset_midop;
        int   cyc;
        bit   ok;
        bit   stray;
        exp_t e;
        issue(8'h40, 1);
        wait_done(cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || shifted_result !== e.res || overflow !== e.ovf) begin
            n_err++;
            $display("FAIL pre_reset_op: ok=%0d res=%h ovf=%b, want 1 %h/%b",
                     ok, shifted_result, overflow, e.res, e.ovf);
        end
        @(posedge clk); #1;
        issue(8'h01, 7);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        n_cmp++;
        if ({busy, done, shifted_result, overflow} !== 11'b0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b res=%h ovf=%b, want 0/0/00/0",
                     busy, done, shifted_result, overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stray) begin
            n_err++;
            $display("FAIL reset_abort: done/busy seen after aborted op, want none");
        end
        issue(8'h05, 1);
        wait_done(cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || cyc != 1 || shifted_result !== e.res || overflow !== e.ovf) begin
            n_err++;
            $display("FAIL post_reset_op: ok=%0d cyc=%0d res=%h ovf=%b, want 1 1 %h/%b",
                     ok, cyc, shifted_result, overflow, e.res, e.ovf);
        end
        last_res = e.res;
        last_ovf = e.ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int           cyc;
        bit           ok;
        int           k;
        logic [N-1:0] d;
        exp_t         e;
        for (int i = 0; i < 20; i++) begin
            d = N'($urandom);
            k = $urandom_range(0, N - 1);
            issue(d, k);
            wait_done(cyc, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL b2b%0d_timeout: no done, d=%h k=%0d", i, d, k);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if (cyc != k || shifted_result !== e.res || overflow !== e.ovf) begin
                    n_err++;
                    $display("FAIL b2b%0d: d=%h k=%0d cyc=%0d res=%h ovf=%b, want cyc=%0d %h/%b",
                             i, d, k, cyc, shifted_result, overflow, k, e.res, e.ovf);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_busy_window();
        test_vectors();
        test_ignored_start();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sequential_arithmetic_left_shifter.md
Name: sequential_arithmetic_left_shifter

Overview:
Multi-cycle arithmetic left shifter. It is the opposite-direction companion to the team's combinational arithmetic right shifter.
- Accepts an N-bit signed operand and a shift amount on a start pulse.
- Shifts left by one bit per clock.
- Reports the result, a sticky signed-overflow flag and a one-cycle done strobe.
- Sits in the datapath where area matters more than latency, driven by a simple start/busy/done handshake.

Parameters:
N, 8, operand/result width in bits (N >= 2).
SHW, $clog2(N), width of shift_amount; legal amounts are 0..N-1.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
input_data  input  N  signed operand, sampled with an accepted start.
shift_amount  input  SHW  left-shift distance, sampled with an accepted start.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle strobe: result and overflow are valid.
shifted_result  output  N  final shifted value, held until the next accepted start.
overflow  output  1  high if the signed value changed sign or magnitude; held with the result.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, shifted_result=0, overflow=0, internal count=0.
- Reset asserted mid-operation aborts immediately; the same values apply and no done is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1 (acceptance edge E0):
  - load the working register with input_data and count with shift_amount; clear overflow.
  - amount=0: go to DONE; shifted_result=input_data, overflow=0.
  - amount>0: go to SHIFT.
- IDLE with start=0: stay in IDLE; all outputs hold.
- SHIFT, each edge:
  - overflow |= (reg[N-1] ^ reg[N-2]), evaluated before the shift.
  - reg <= reg << 1 with zero fill; count <= count-1.
  - When count==1 at that edge: go to DONE and copy the shifted value to shifted_result.
- DONE: done=1 for exactly this cycle, then unconditionally go to IDLE.
- Latency: done is high in the cycle following edge E0+k, where k = shift_amount. For k=0 that is the cycle right after E0.
- Throughput: one operation per k+2 cycles. A start during SHIFT or DONE is ignored (not queued). start may be asserted in the IDLE cycle immediately after DONE.
- Overflow equivalence: overflow=1 iff input_data[N-1 : N-1-k] are not all equal. It is therefore always 0 for k=0.
- Width rules:
  - The result is always exactly N bits; bits shifted out are discarded, only their effect on overflow is kept.
  - shift_amount is unsigned; values >= N are outside the contract and need not be handled.
- shifted_result and overflow change only on acceptance of an amount-0 request or on the SHIFT->DONE edge. Otherwise they hold, including while busy.
- input_data and shift_amount may change freely after acceptance without affecting the operation in flight.

Decomposition:
- Shared package:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} shl_state_t.
  - SHW computation helper/constant for the default width.
- Single flat module; no sub-module is natural, since the datapath is one register, one down-counter and one XOR term.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT -> busy=0, done=0, shifted_result=8'h00, overflow=0 immediately (asynchronous). Next start is accepted normally.
- input_data=8'b0000_0011, shift_amount=2 -> done after E0+2, shifted_result=8'b0000_1100, overflow=0, busy high for 3 cycles.
- input_data=8'b1111_0000, shift_amount=3 -> shifted_result=8'b1000_0000, overflow=0. Then input_data=8'b0100_0000, shift_amount=1 -> shifted_result=8'b1000_0000, overflow=1.
- input_data=8'b1010_1010, shift_amount=0 -> done in the cycle after E0, shifted_result=8'b1010_1010, overflow=0.
- input_data=8'b0000_0001, shift_amount=7 -> done after E0+7, shifted_result=8'b1000_0000, overflow=1.
- Second start (8'hFF, amount 1) pulsed during SHIFT of a running 8'h03/amount-2 operation:
  - ignored; result 8'h0C;
  - exactly one done;
  - 20 random back-to-back operations checked against a reference model of (input_data << k) and the overflow rule.
